// File: rtl/log_mem_ctrl_pkg.sv
// Shared project package for the capture log: FSM state encoding, default
// geometry and register-file command codes.
package log_mem_ctrl_pkg;

  localparam int unsigned NB_ADDR_MEM_DEF = 15;
  localparam int unsigned NB_DATA_DEF     = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_LOG  = 2'd2,
    ST_FULL = 2'd3
  } log_state_e;

  typedef enum logic [3:0] {
    CMD_NOP      = 4'h0,
    CMD_RUN_LOG  = 4'h1,
    CMD_READ_LOG = 4'h2,
    CMD_SET_ADDR = 4'h3
  } rf_cmd_e;

  function automatic logic state_is_busy(input log_state_e s);
    return (s == ST_ARM) || (s == ST_LOG);
  endfunction

endpackage

// File: rtl/log_mem_ctrl_if.sv
// Register-file / datapath side bundle of the capture log controller.
interface log_mem_ctrl_if #(
  parameter int unsigned NB_ADDR_MEM = 15,
  parameter int unsigned NB_DATA     = 32
);
  logic                   i_run_log;
  logic                   i_read_log;
  logic [NB_ADDR_MEM-1:0] i_addr_log;
  logic [NB_DATA-1:0]     i_data;
  logic                   i_valid;
  logic [NB_DATA-1:0]     o_data_log;
  logic                   o_mem_full;
  logic                   o_busy;
  logic [NB_ADDR_MEM-1:0] o_wr_addr;

  modport slave (
    input  i_run_log, i_read_log, i_addr_log, i_data, i_valid,
    output o_data_log, o_mem_full, o_busy, o_wr_addr
  );

  modport master (
    output i_run_log, i_read_log, i_addr_log, i_data, i_valid,
    input  o_data_log, o_mem_full, o_busy, o_wr_addr
  );
endinterface

// File: rtl/log_mem_ctrl_log_ram.sv
// Simple dual-port log storage: one write port, one registered read port.
module log_ram #(
  parameter int unsigned NB_ADDR = 15,
  parameter int unsigned NB_DATA = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               we,
  input  logic [NB_ADDR-1:0] wr_addr,
  input  logic [NB_DATA-1:0] wr_data,
  input  logic               re,
  input  logic [NB_ADDR-1:0] rd_addr,
  output logic [NB_DATA-1:0] rd_data
);

  logic [NB_DATA-1:0] mem [2**NB_ADDR];

  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  // Output register keeps its value when no read is issued.
  always_ff @(posedge clk) begin
    if (rst)     rd_data <= '0;
    else if (re) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/log_mem_ctrl.sv
// Capture log controller: on a run edge, records DEPTH qualified samples into
// log_ram, then holds them for address readout by the register file.
module log_mem_ctrl
  import log_mem_ctrl_pkg::*;
#(
  parameter int unsigned NB_ADDR_MEM = NB_ADDR_MEM_DEF,
  parameter int unsigned NB_DATA     = NB_DATA_DEF
) (
  input  logic                 clk,
  input  logic                 i_rst,
  log_mem_ctrl_if.slave        bus
);

  log_state_e             state, state_nxt;
  logic [NB_ADDR_MEM-1:0] ptr, ptr_nxt;
  logic                   full, full_nxt;
  logic                   run_d, run_block, run_edge;
  logic                   we, re;
  logic [NB_DATA-1:0]     rd_data;

  // run_block suppresses a false edge when i_run_log is still high across reset;
  // a genuine 0->1 transition is required afterwards.
  assign run_edge = bus.i_run_log & ~run_d & ~run_block;

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    full_nxt  = full;
    we        = 1'b0;
    re        = 1'b0;
    if (run_edge) begin
      state_nxt = ST_ARM;
      ptr_nxt   = '0;
      full_nxt  = 1'b0;
    end else begin
      unique case (state)
        ST_IDLE, ST_FULL: re = bus.i_read_log;
        ST_ARM, ST_LOG: begin
          if (bus.i_valid) begin
            we      = 1'b1;
            ptr_nxt = ptr + NB_ADDR_MEM'(1);
            if (ptr == '1) begin
              state_nxt = ST_FULL;
              full_nxt  = 1'b1;
            end else begin
              state_nxt = ST_LOG;
            end
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      state     <= ST_IDLE;
      ptr       <= '0;
      full      <= 1'b0;
      run_d     <= 1'b0;
      run_block <= bus.i_run_log;
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      full      <= full_nxt;
      run_d     <= bus.i_run_log;
      run_block <= run_block & bus.i_run_log;
    end
  end

  log_ram #(
    .NB_ADDR (NB_ADDR_MEM),
    .NB_DATA (NB_DATA)
  ) u_log_ram (
    .clk     (clk),
    .rst     (i_rst),
    .we      (we & ~i_rst),
    .wr_addr (ptr),
    .wr_data (bus.i_data),
    .re      (re & ~i_rst),
    .rd_addr (bus.i_addr_log),
    .rd_data (rd_data)
  );

  assign bus.o_busy     = state_is_busy(state);
  assign bus.o_mem_full = full;
  assign bus.o_wr_addr  = ptr;
  assign bus.o_data_log = rd_data;

endmodule

// File: tb/tb_log_mem_ctrl.sv
// Self-checking bench for log_mem_ctrl (DEPTH=16): directed capture/readout
// scenarios, a readout vector table and randomized traffic against a model.
module tb_log_mem_ctrl;

  localparam int unsigned AW    = 4;
  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 16;

  logic clk;
  logic rst;

  log_mem_ctrl_if #(.NB_ADDR_MEM(AW), .NB_DATA(DW)) bus ();

  log_mem_ctrl #(.NB_ADDR_MEM(AW), .NB_DATA(DW)) dut (
    .clk   (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: capture progress counted in samples, memory as an array.
  bit          m_capturing;
  bit          m_full;
  int          m_count;
  logic [31:0] m_mem [DEPTH];
  bit          m_known [DEPTH];
  logic [31:0] m_data;
  bit          m_data_known;
  bit          m_prev_run;
  bit          m_block;

  typedef struct {
    logic        read;
    logic [3:0]  addr;
    logic [31:0] exp;
  } rd_vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_update();
    bit edge_seen;
    if (rst) begin
      m_capturing  = 0;
      m_full       = 0;
      m_count      = 0;
      m_data       = '0;
      m_data_known = 1;
      m_prev_run   = 0;
      m_block      = bus.i_run_log;
    end else begin
      edge_seen  = bus.i_run_log && !m_prev_run && !m_block;
      m_prev_run = bus.i_run_log;
      if (!bus.i_run_log) m_block = 0;
      if (edge_seen) begin
        m_capturing = 1;
        m_full      = 0;
        m_count     = 0;
      end else if (m_capturing) begin
        if (bus.i_valid) begin
          m_mem[m_count]   = bus.i_data;
          m_known[m_count] = 1;
          m_count++;
          if (m_count == DEPTH) begin
            m_count     = 0;
            m_capturing = 0;
            m_full      = 1;
          end
        end
      end else if (bus.i_read_log) begin
        m_data       = m_mem[bus.i_addr_log];
        m_data_known = m_known[bus.i_addr_log];
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
    chk("busy", {31'd0, bus.o_busy}, {31'd0, m_capturing});
    chk("mem_full", {31'd0, bus.o_mem_full}, {31'd0, m_full});
    chk("wr_addr", {28'd0, bus.o_wr_addr}, 32'(m_count));
    if (m_data_known) chk("data_log", bus.o_data_log, m_data);
  endtask

  task automatic cyc(input logic run, input logic rd, input logic [3:0] addr,
                     input logic valid, input logic [31:0] data);
    bus.i_run_log  = run;
    bus.i_read_log = rd;
    bus.i_addr_log = addr;
    bus.i_valid    = valid;
    bus.i_data     = data;
    step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rd_vec_t tbl [5];
    logic    run_r;
    tbl[0] = '{read: 1'b1, addr: 4'd5,  exp: 32'h0000_A005};
    tbl[1] = '{read: 1'b1, addr: 4'd15, exp: 32'h0000_A00F};
    tbl[2] = '{read: 1'b0, addr: 4'd3,  exp: 32'h0000_A00F};
    tbl[3] = '{read: 1'b1, addr: 4'd0,  exp: 32'h0000_A000};
    tbl[4] = '{read: 1'b1, addr: 4'd3,  exp: 32'h0000_A003};

    for (int i = 0; i < int'(DEPTH); i++) m_known[i] = 0;
    m_data_known = 0;
    m_prev_run   = 0;
    m_block      = 0;

    // Reset then idle.
    rst = 1'b1;
    cyc(0, 0, 0, 0, 0);
    rst = 1'b0;
    repeat (10) cyc(0, 0, 0, 0, 0);
    chk("rst_full", {31'd0, bus.o_mem_full}, 32'd0);
    chk("rst_busy", {31'd0, bus.o_busy}, 32'd0);
    chk("rst_data", bus.o_data_log, 32'd0);
    chk("rst_wr_addr", {28'd0, bus.o_wr_addr}, 32'd0);

    // Capture with a sample every 4th clock.
    cyc(1, 0, 0, 0, 0);
    chk("arm_busy", {31'd0, bus.o_busy}, 32'd1);
    for (int n = 0; n < 16; n++) begin
      repeat (3) cyc(1, 0, 0, 0, 32'hDEAD_0000);
      cyc(1, 0, 0, 1, 32'hA000 + 32'(n));
      if (n < 15) chk("cap_busy", {31'd0, bus.o_busy}, 32'd1);
    end
    chk("cap_done_full", {31'd0, bus.o_mem_full}, 32'd1);
    chk("cap_done_busy", {31'd0, bus.o_busy}, 32'd0);
    cyc(0, 0, 0, 0, 0);

    // Readout vector table, including a hold cycle with i_read_log low.
    for (int i = 0; i < 5; i++) begin
      cyc(0, tbl[i].read, tbl[i].addr, 0, 0);
      chk("rd_tbl", bus.o_data_log, tbl[i].exp);
    end

    // Continuous valid after full must not write.
    for (int i = 0; i < 40; i++) cyc(0, 0, 0, 1, $urandom);
    chk("full_hold", {31'd0, bus.o_mem_full}, 32'd1);
    chk("full_wr_addr", {28'd0, bus.o_wr_addr}, 32'd0);
    for (int i = 0; i < int'(DEPTH); i++) begin
      cyc(0, 1, 4'(i), 0, 0);
      chk("full_contents", bus.o_data_log, 32'hA000 + 32'(i));
    end

    // Restart during LOG after 7 writes.
    cyc(1, 0, 0, 0, 0);
    for (int i = 0; i < 7; i++) cyc(1, 0, 0, 1, $urandom);
    chk("abort_wr_addr", {28'd0, bus.o_wr_addr}, 32'd7);
    cyc(0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    chk("restart_wr_addr", {28'd0, bus.o_wr_addr}, 32'd0);
    for (int n = 0; n < 16; n++) cyc(1, 0, 0, 1, 32'hB000 + 32'(n));
    cyc(0, 1, 4'd0, 0, 0);
    chk("restart_rd0", bus.o_data_log, 32'h0000_B000);
    cyc(0, 1, 4'd15, 0, 0);
    chk("restart_rd15", bus.o_data_log, 32'h0000_B00F);

    // Reset mid-capture with run held high; needs a fresh 0->1 to restart.
    cyc(1, 0, 0, 0, 0);
    for (int i = 0; i < 9; i++) cyc(1, 0, 0, 1, $urandom);
    rst = 1'b1;
    cyc(1, 0, 0, 1, $urandom);
    rst = 1'b0;
    chk("rst_mid_busy", {31'd0, bus.o_busy}, 32'd0);
    chk("rst_mid_full", {31'd0, bus.o_mem_full}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      cyc(1, 0, 0, 1, $urandom);
      chk("held_run_busy", {31'd0, bus.o_busy}, 32'd0);
    end
    cyc(0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    chk("rerun_busy", {31'd0, bus.o_busy}, 32'd1);

    // Randomized traffic against the model.
    run_r = 1'b1;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 40) == 0) run_r = ~run_r;
      rst = ($urandom_range(0, 250) == 0);
      cyc(run_r, 1'($urandom), 4'($urandom), 1'($urandom), $urandom);
    end
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/log_mem_ctrl.md
LOG_MEM_CTRL -- requirements
Module: log_mem_ctrl

Interface
REQ-001 Parameter NB_ADDR_MEM, default 15, SHALL set log memory address width; depth = 2**NB_ADDR_MEM words.
REQ-002 Parameter NB_DATA, default 32, SHALL set logged word width.
REQ-003 clk  in  1  sole clock; all logic on rising edge.
REQ-004 i_rst  in  1  reset, synchronous, active-high.
REQ-005 i_run_log  in  1  capture request level from register file; rising edge starts a capture.
REQ-006 i_read_log  in  1  read enable from register file; high = address readout mode.
REQ-007 i_addr_log  in  NB_ADDR_MEM  read address from register file.
REQ-008 i_data  in  NB_DATA  sample word from Tx/Rx datapath.
REQ-009 i_valid  in  1  qualifies i_data for one clk.
REQ-010 o_data_log  out  NB_DATA  word read from memory, to register file.
REQ-011 o_mem_full  out  1  capture complete, memory holds DEPTH valid words.
REQ-012 o_busy  out  1  high in ARM or LOG.
REQ-013 o_wr_addr  out  NB_ADDR_MEM  current write pointer, debug.

Function
REQ-014 FSM SHALL have states IDLE, ARM, LOG, FULL.
REQ-015 Rising edge of i_run_log (registered compare, one-cycle detect) SHALL move any state to ARM, clear o_mem_full, set write pointer to 0.
REQ-016 ARM SHALL move to LOG on first cycle with i_valid=1; that sample SHALL be written at address 0 in the same cycle.
REQ-017 In LOG each i_valid=1 cycle SHALL write i_data at write pointer and increment pointer; i_valid=0 cycles write nothing.
REQ-018 Write at address DEPTH-1 SHALL move FSM to FULL next cycle with o_mem_full=1; pointer SHALL wrap to 0, no further writes.
REQ-019 FULL SHALL hold until next i_run_log rising edge or reset; i_valid ignored.
REQ-020 In IDLE or FULL with i_read_log=1, memory SHALL be read at i_addr_log; o_data_log valid 1 clk after address presented (registered).
REQ-021 In ARM/LOG, or with i_read_log=0, o_data_log SHALL hold its last value.
REQ-022 Run edge coincident with i_read_log=1 SHALL take priority; no read occurs that cycle.
REQ-023 Run edge during LOG SHALL abort and restart at address 0; old contents beyond new pointer undefined to readers.
REQ-024 i_run_log held high SHALL NOT retrigger; only 0->1 transitions count.
REQ-025 o_busy SHALL be combinationally decoded from state; all other outputs registered.

Reset
REQ-026 i_rst SHALL force state IDLE, pointer 0, o_mem_full 0, o_busy 0, o_data_log 0, run edge detector history 0.
REQ-027 Reset mid-capture SHALL abort without further writes; memory contents not cleared.
REQ-028 Reset SHALL take priority over all other inputs in the same cycle.

Structure
REQ-029 State encoding and default NB_ADDR_MEM/NB_DATA SHALL live in the shared project package alongside register-file command codes.
REQ-030 Storage SHALL be a separate sub-module log_ram: simple dual-port, one write port, one registered read port, inferable as block RAM.
REQ-031 Target size 150-300 RTL lines including log_ram.

Verification (bench with NB_ADDR_MEM=4, DEPTH=16)
REQ-032 Reset then idle 10 clk -> o_mem_full=0, o_busy=0, o_data_log=0, o_wr_addr=0.
REQ-033 i_run_log 0->1, then i_valid every 4th clk with i_data=0xA000+n, n=0..15 -> o_busy=1 until 16th write, o_mem_full=1 one clk after, o_busy=0.
REQ-034 After REQ-033, i_read_log=1, i_addr_log=5 -> o_data_log=0x0000A005 one clk later; addr 15 -> 0x0000A00F.
REQ-035 i_valid=1 continuously for 40 clk after capture full -> exactly 16 writes, contents unchanged, o_mem_full stays 1.
REQ-036 Run edge after 7 writes, then 16 samples 0xB000+n -> addr 0 reads 0x0000B000, addr 15 reads 0x0000B00F.
REQ-037 i_rst=1 for 1 clk after 9 writes -> IDLE, o_busy=0, o_mem_full=0; i_run_log held high afterwards does not start capture until it drops and rises.
